// File: rtl/ccm_pkg.sv
// Shared constants for the colour-correction pixel path: Q16.16 format, identity matrix,
// coefficient and pixel-channel bit offsets.
// No logic of its own; used by ccm_pixel_apply and ccm_row_mac.
package ccm_pkg;

   localparam int FRAC_BITS = 16;
   localparam int COEF_W    = 32;
   localparam int MAT_W     = 9 * COEF_W;

   localparam logic [COEF_W-1:0] FP_ONE = 32'h0001_0000;

   // Element (r,c) lives at 32*(3r+c); the diagonal is elements 0, 4 and 8.
   localparam logic [MAT_W-1:0] IDENTITY_MATRIX =
      {FP_ONE, {3{32'h0}}, FP_ONE, {3{32'h0}}, FP_ONE};

   // Channel indices: row/column 0 is R, 1 is G, 2 is B.
   localparam int CH_R = 0;
   localparam int CH_G = 1;
   localparam int CH_B = 2;

   // Bit offset of coefficient (row, col) inside the packed matrix.
   function automatic int coef_off(input int row, input int col);
      return COEF_W * (3 * row + col);
   endfunction

   // Bit offset of the first coefficient of a matrix row.
   function automatic int row_off(input int row);
      return COEF_W * 3 * row;
   endfunction

   // Bit offset of a channel inside a packed pixel (R is the most significant).
   function automatic int chan_off(input int ch, input int pix_w);
      return (2 - ch) * pix_w;
   endfunction

endpackage

// File: rtl/ccm_row_mac.sv
// One output channel of the colour matrix: three products, row sum, round, clamp to PIX_W.
// Latency: 3 enabled cycles (products, sum, round/clamp register).
// Backpressure: every stage holds while en=0; bypass returns this row's own input channel.
module ccm_row_mac import ccm_pkg::*; #(
   parameter int PIX_W     = 8,
   parameter int FRAC_BITS = 16,
   parameter int ROW       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [3*PIX_W-1:0]    pix,
   input  logic [3*COEF_W-1:0]   coef,
   input  logic                  byp,
   output logic [PIX_W-1:0]      chan_out
);

   localparam int PROD_W = PIX_W + 1 + COEF_W;
   localparam int SUM_W  = PROD_W + 2;
   localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) <<< (FRAC_BITS - 1);

   logic signed [PROD_W-1:0] prod_d [3];
   logic signed [PROD_W-1:0] prod_q [3];
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [SUM_W-1:0]  rnd;
   logic signed [SUM_W-1:0]  shf;
   logic [PIX_W-1:0]         clamped;
   logic                     byp1, byp2;
   logic [PIX_W-1:0]         pass1, pass2;

   // Channels are unsigned, so zero-extend before the signed multiply.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         prod_d[i] = PROD_W'($signed({1'b0, pix[chan_off(i, PIX_W) +: PIX_W]}))
                   * PROD_W'($signed(coef[COEF_W*i +: COEF_W]));
      end
   end

   // S1: register the products together with the bypass flag and original channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '{default: '0};
         byp1   <= 1'b0;
         pass1  <= '0;
      end else if (en) begin
         prod_q <= prod_d;
         byp1   <= byp;
         pass1  <= pix[chan_off(ROW, PIX_W) +: PIX_W];
      end
   end

   // S2: sign-extended row sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
         byp2  <= 1'b0;
         pass2 <= '0;
      end else if (en) begin
         sum_q <= SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]);
         byp2  <= byp1;
         pass2 <= pass1;
      end
   end

   // Round half up, drop the fraction, saturate to [0, 2^PIX_W-1].
   always_comb begin
      rnd = sum_q + HALF;
      shf = rnd >>> FRAC_BITS;
      if (shf[SUM_W-1])
         clamped = '0;
      else if (|shf[SUM_W-2:PIX_W])
         clamped = '1;
      else
         clamped = shf[PIX_W-1:0];
   end

   // S3: output register.
   always_ff @(posedge clk) begin
      if (rst)
         chan_out <= '0;
      else if (en)
         chan_out <= byp2 ? pass2 : clamped;
   end

endmodule

// File: rtl/ccm_pixel_apply.sv
// Applies a double-buffered 3x3 Q16.16 matrix to an RGB pixel stream; counts frames.
// Latency: 3 enabled cycles from input accept to m_valid.
// Backpressure: whole pipeline stalls while m_valid & !m_ready; s_ready = !m_valid | m_ready.
module ccm_pixel_apply import ccm_pkg::*; #(
   parameter int PIX_W     = 8,
   parameter int FRAC_BITS = 16,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [MAT_W-1:0]    comp_matrix,
   input  logic                matrix_valid,
   input  logic                bypass,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [3*PIX_W-1:0]  s_data,
   input  logic                s_sof,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [3*PIX_W-1:0]  m_data,
   output logic                m_sof,
   output logic                matrix_pending,
   output logic [CNT_W-1:0]    frame_count
);

   logic             en;
   logic             accept;
   logic             commit;
   logic [MAT_W-1:0] active_q;
   logic [MAT_W-1:0] pending_q;
   logic [MAT_W-1:0] mat_use;
   logic [2:0]       vld_q;
   logic [2:0]       sof_q;

   assign m_valid = vld_q[2];
   assign m_sof   = sof_q[2];
   assign en      = ~m_valid | m_ready;
   assign s_ready = en;
   assign accept  = s_valid & en;
   assign commit  = accept & s_sof & matrix_pending;

   // The committing SOF pixel already sees the new matrix.
   assign mat_use = commit ? pending_q : active_q;

   // Matrix double buffer: commit uses the old pending value, a same-cycle new matrix re-arms.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q       <= IDENTITY_MATRIX;
         pending_q      <= IDENTITY_MATRIX;
         matrix_pending <= 1'b0;
      end else begin
         if (commit)
            active_q <= pending_q;
         if (matrix_valid) begin
            pending_q      <= comp_matrix;
            matrix_pending <= 1'b1;
         end else if (commit) begin
            matrix_pending <= 1'b0;
         end
      end
   end

   // Valid and SOF shift alongside the datapath; bubbles enter as invalid stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         sof_q <= '0;
      end else if (en) begin
         vld_q <= {vld_q[1:0], accept};
         sof_q <= {sof_q[1:0], accept & s_sof};
      end
   end

   // Frame counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst)
         frame_count <= '0;
      else if (accept & s_sof)
         frame_count <= frame_count + 1'b1;
   end

   genvar r;
   for (r = 0; r < 3; r++) begin : g_row
      ccm_row_mac #(
         .PIX_W     (PIX_W),
         .FRAC_BITS (FRAC_BITS),
         .ROW       (r)
      ) u_row (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .pix      (s_data),
         .coef     (mat_use[row_off(r) +: 3*COEF_W]),
         .byp      (bypass),
         .chan_out (m_data[chan_off(r, PIX_W) +: PIX_W])
      );
   end

endmodule

// File: tb/tb_ccm_pixel_apply.sv
// Bench for ccm_pixel_apply: directed steps plus a randomized phase against a reference model.
// The model computes each expected pixel with integer arithmetic from the active matrix.
// Outputs and inputs are observed on the falling edge, away from the active edge.
module tb_ccm_pixel_apply;
   import ccm_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [287:0]  comp_matrix = '0;
   logic          matrix_valid = 1'b0;
   logic          bypass = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [23:0]   s_data = '0;
   logic          s_sof = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [23:0]   m_data;
   logic          m_sof;
   logic          matrix_pending;
   logic [15:0]   frame_count;

   ccm_pixel_apply #(.PIX_W(8), .FRAC_BITS(16), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .comp_matrix    (comp_matrix),
      .matrix_valid   (matrix_valid),
      .bypass         (bypass),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .s_sof          (s_sof),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .m_sof          (m_sof),
      .matrix_pending (matrix_pending),
      .frame_count    (frame_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int out_count = 0;

   typedef struct {
      logic [23:0] dat;
      logic        sof;
   } exp_t;

   exp_t    expq[$];
   longint  act_m[9];
   longint  pend_m[9];
   longint  use_m[9];
   bit      mflag = 0;
   int      mcount = 0;
   bit      armed = 0;
   bit      hold_vld = 0;
   logic [24:0] hold_dat;
   exp_t    e;
   longint  acc;
   logic [23:0] res;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [287:0] diag_mat(input logic [31:0] d);
      logic [287:0] m;
      m = '0;
      for (int k = 0; k < 3; k++) m[32*(4*k) +: 32] = d;
      return m;
   endfunction

   function automatic logic [287:0] rand_mat();
      logic [287:0] m;
      for (int k = 0; k < 9; k++) begin
         if ($urandom_range(0, 3) == 0)
            m[32*k +: 32] = $urandom;
         else
            m[32*k +: 32] = 32'($urandom_range(0, 32'h40000)) - 32'h20000;
      end
      return m;
   endfunction

   // Reference model: matrix state, expected-output queue and frame count.
   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
         for (int k = 0; k < 9; k++) begin
            act_m[k]  = (k % 4 == 0) ? 64'sd65536 : 64'sd0;
            pend_m[k] = act_m[k];
         end
         mflag    = 0;
         mcount   = 0;
         hold_vld = 0;
         armed    = 1;
      end else if (armed) begin
         chk("matrix_pending", 64'(matrix_pending), 64'(mflag));
         chk("frame_count", 64'(frame_count), 64'(mcount));
         if (hold_vld && m_valid)
            chk("hold_stable", 64'({m_sof, m_data}), 64'(hold_dat));
         hold_vld = m_valid && !m_ready;
         hold_dat = {m_sof, m_data};

         if (m_valid && m_ready) begin
            out_count++;
            checks++;
            assert (expq.size() != 0) else begin
               errors++;
               $error("FAIL spurious_output observed=%0h expected=none", m_data);
            end
            if (expq.size() != 0) begin
               e = expq.pop_front();
               chk("out_data", 64'(m_data), 64'(e.dat));
               chk("out_sof", 64'(m_sof), 64'(e.sof));
            end
         end

         if (s_valid && s_ready) begin
            for (int k = 0; k < 9; k++)
               use_m[k] = (s_sof && mflag) ? pend_m[k] : act_m[k];
            if (bypass) begin
               res = s_data;
            end else begin
               for (int rr = 0; rr < 3; rr++) begin
                  acc = 0;
                  for (int cc = 0; cc < 3; cc++)
                     acc += use_m[3*rr+cc] * longint'(s_data[8*(2-cc) +: 8]);
                  acc = (acc + 32768) >>> 16;
                  if (acc < 0) acc = 0;
                  else if (acc > 255) acc = 255;
                  res[8*(2-rr) +: 8] = 8'(acc);
               end
            end
            e.dat = res;
            e.sof = s_sof;
            expq.push_back(e);
            if (s_sof) begin
               mcount = (mcount + 1) % 65536;
               if (mflag) begin
                  act_m = pend_m;
                  mflag = 0;
               end
            end
         end

         if (matrix_valid) begin
            for (int k = 0; k < 9; k++)
               pend_m[k] = longint'($signed(comp_matrix[32*k +: 32]));
            mflag = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] p, input logic sof, input logic byp);
      s_valid = 1'b1;
      s_data  = p;
      s_sof   = sof;
      bypass  = byp;
      step();
      s_valid = 1'b0;
      s_sof   = 1'b0;
      bypass  = 1'b0;
   endtask

   task automatic load_matrix(input logic [287:0] m);
      comp_matrix  = m;
      matrix_valid = 1'b1;
      step();
      matrix_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input logic [23:0] exp);
      for (int i = 0; i < 20; i++) begin
         if (m_valid && m_ready) break;
         step();
      end
      chk({tag, "_valid"}, 64'(m_valid), 64'(1));
      chk(tag, 64'(m_data), 64'(exp));
   endtask

   // Called right after the accept edge: output must appear on the third edge.
   task automatic lat_check(input string tag, input logic [23:0] exp);
      chk({tag, "_lat1"}, 64'(m_valid), 64'(0));
      step();
      chk({tag, "_lat2"}, 64'(m_valid), 64'(0));
      step();
      chk({tag, "_lat3"}, 64'(m_valid), 64'(1));
      chk(tag, 64'(m_data), 64'(exp));
   endtask

   initial begin
      logic [287:0] m;
      int base;
      int idx;
      bit acc_now;

      repeat (3) step();
      rst = 1'b0;

      // Reset state.
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_m_data", 64'(m_data), 64'(0));
      chk("rst_m_sof", 64'(m_sof), 64'(0));
      chk("rst_frame_count", 64'(frame_count), 64'(0));
      chk("rst_pending", 64'(matrix_pending), 64'(0));
      chk("rst_s_ready", 64'(s_ready), 64'(1));

      // Identity matrix passes the pixel through with 3-cycle latency.
      send(24'h0A141E, 1'b0, 1'b0);
      lat_check("identity", 24'h0A141E);
      chk("identity_pending", 64'(matrix_pending), 64'(0));
      step();

      // Half-gain diagonal, round half up.
      load_matrix(diag_mat(32'h0000_8000));
      chk("half_pending_set", 64'(matrix_pending), 64'(1));
      send(24'hFF0100, 1'b1, 1'b0);
      chk("half_pending_clr", 64'(matrix_pending), 64'(0));
      chk("half_frame_count", 64'(frame_count), 64'(1));
      wait_out("half_round", 24'h800100);

      // Negative coefficient clamps R to 0.
      m = diag_mat(FP_ONE);
      m[32*1 +: 32] = 32'hFFFF_0000;
      load_matrix(m);
      send(24'h006400, 1'b1, 1'b0);
      wait_out("clamp_low", 24'h006400);

      // Gain 2 saturates to 255.
      load_matrix(diag_mat(32'h0002_0000));
      send(24'hC8C8C8, 1'b1, 1'b0);
      chk("sat_frame_count", 64'(frame_count), 64'(3));
      wait_out("clamp_high", 24'hFFFFFF);

      // Mid-frame update waits for the next SOF.
      send(24'h323C46, 1'b0, 1'b0);
      wait_out("mid_old1", 24'h64788C);
      load_matrix(diag_mat(FP_ONE));
      chk("mid_pending_set", 64'(matrix_pending), 64'(1));
      send(24'h323C46, 1'b0, 1'b0);
      chk("mid_pending_hold", 64'(matrix_pending), 64'(1));
      wait_out("mid_old2", 24'h64788C);
      send(24'h323C46, 1'b1, 1'b0);
      chk("mid_pending_clr", 64'(matrix_pending), 64'(0));
      wait_out("mid_new", 24'h323C46);
      step();

      // Eight pixels with a five-cycle downstream stall in the middle.
      base = out_count;
      idx  = 0;
      for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
         s_valid = 1'b1;
         s_data  = 24'(idx * 32'h111111 + 32'h010203);
         m_ready = !(cyc >= 4 && cyc < 9);
         #1;
         if (!m_ready) begin
            chk("stall_m_valid", 64'(m_valid), 64'(1));
            chk("stall_s_ready", 64'(s_ready), 64'(0));
         end
         acc_now = s_ready;
         step();
         if (acc_now) idx++;
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (6) step();
      chk("stall_out_count", 64'(out_count - base), 64'(8));

      // Bypass with a non-identity matrix keeps latency and data.
      load_matrix(diag_mat(32'h0002_0000));
      send(24'h123456, 1'b1, 1'b1);
      lat_check("bypass", 24'h123456);
      send(24'h0A141E, 1'b0, 1'b0);
      wait_out("post_bypass", 24'h14283C);
      step();

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         s_valid      = ($urandom_range(0, 3) != 0);
         s_data       = 24'($urandom);
         s_sof        = ($urandom_range(0, 7) == 0);
         bypass       = ($urandom_range(0, 7) == 0);
         m_ready      = ($urandom_range(0, 3) != 0);
         matrix_valid = ($urandom_range(0, 15) == 0);
         comp_matrix  = rand_mat();
         step();
      end
      s_valid = 1'b0;
      s_sof = 1'b0;
      bypass = 1'b0;
      matrix_valid = 1'b0;
      m_ready = 1'b1;
      repeat (6) step();
      chk("random_drain", 64'(expq.size()), 64'(0));

      // Reset in the middle of a burst.
      load_matrix(diag_mat(32'h0000_8000));
      send(24'h204060, 1'b1, 1'b0);
      s_valid = 1'b1;
      s_data  = 24'h556677;
      step();
      step();
      rst = 1'b1;
      step();
      chk("midrst_m_valid", 64'(m_valid), 64'(0));
      chk("midrst_m_data", 64'(m_data), 64'(0));
      chk("midrst_frame_count", 64'(frame_count), 64'(0));
      rst = 1'b0;
      s_valid = 1'b0;
      step();
      send(24'h0A141E, 1'b0, 1'b0);
      lat_check("midrst_identity", 24'h0A141E);
      repeat (4) step();
      chk("final_drain", 64'(expq.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
